count_extend_fifo: RTL and testbench

Downstream consumer of the 4-bit parallel-carry counter. Tracks the counter's registered 4-bit output, detects each 15→0 wrap, and extends the count to 8 bits with a 4-bit epoch nibble. Each distinct new count value is queued in a 4-entry FIFO and delivered to the next stage over a valid/ready handshake. Counter values that arrive while the FIFO is full are flagged with a sticky overflow bit.

---
 rtl/count_extend_fifo_if.sv | 27 ++
 rtl/count_extend_fifo.sv | 99 +++++++++
 tb/tb_count_extend_fifo.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/count_extend_fifo_if.sv
// Output stream of count_extend_fifo: the head word and its valid/ready
// handshake, plus the full and sticky overflow status flags.
interface count_extend_fifo_if;
    logic [7:0] dout;
    logic       valid;
    logic       ready;
    logic       full;
    logic       overflow;

    // Producer side: the FIFO drives data and status, the consumer drives ready.
    modport master (
        output dout,
        output valid,
        output full,
        output overflow,
        input  ready
    );

    // Consumer side of the same stream.
    modport slave (
        input  dout,
        input  valid,
        input  full,
        input  overflow,
        output ready
    );
endinterface

// File: rtl/count_extend_fifo.sv
// count_extend_fifo: follows a 4-bit counter, counts its 15->0 wraps into an
// epoch nibble and queues every new {epoch, count} word in a 4-entry FIFO.
// All state updates on the falling edge of clock.
module count_extend_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_,
    input  logic [3:0]          Q,
    input  logic                en,
    count_extend_fifo_if.master bus
);

    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    logic [3:0] prev;
    logic [3:0] epoch;
    logic [3:0] epoch_n;
    logic       wrap;
    logic       push;
    logic       pop;
    logic       do_write;
    logic       drop;
    logic       not_empty;
    logic       is_full;
    logic       overflow_q;

    logic [7:0] mem [DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] cnt;

    assign not_empty = (cnt != 3'd0);
    assign is_full   = (cnt == FULL_CNT);

    // Next-epoch, push/pop and write/drop decisions for the coming edge.
    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        wrap     = (Q < prev);
        epoch_n  = epoch + {3'b000, wrap};
        push     = en && (Q != prev);
        pop      = not_empty && bus.ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        do_write = push && (!is_full || pop);
        drop     = push && is_full && !pop;
    end

    // Wrap tracking runs on every edge; en only gates the FIFO push.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(negedge clock or negedge reset_) begin
        if (!reset_) begin
            prev  <= 4'd0;
            epoch <= 4'd0;
        end else begin
            prev  <= Q;
            epoch <= epoch_n;
        end
    end

    // Storage write; the word carries the post-wrap epoch.
    // NOTE: storage has no reset; stale entries are invisible because dout is gated by valid.
    always_ff @(negedge clock) begin
        if (do_write) begin
            mem[wr_ptr] <= {epoch_n, Q};
        end
    end

    // Pointers, occupancy and sticky overflow.
    always_ff @(negedge clock or negedge reset_) begin
        if (!reset_) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            cnt        <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({do_write, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Outputs are decoded from registers only.
    assign bus.valid    = not_empty;
    assign bus.full     = is_full;
    assign bus.overflow = overflow_q;
    assign bus.dout     = not_empty ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_count_extend_fifo.sv
// Self-checking bench for count_extend_fifo: a queue scoreboard models the
// epoch tracking and FIFO, and each scenario task compares the DUT against it
// plus a few fixed expected words.
module tb_count_extend_fifo;

    logic       clock  = 1'b1;
    logic       reset_ = 1'b0;
    logic [3:0] Q      = 4'd0;
    logic       en     = 1'b0;

    count_extend_fifo_if bus();

    count_extend_fifo #(.DEPTH(4)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .Q      (Q),
        .en     (en),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [3:0] m_prev  = 4'd0;
    logic [3:0] m_epoch = 4'd0;
    logic       m_ovf   = 1'b0;

    function automatic logic [7:0] exp_head();
        return (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    endfunction

    function automatic logic exp_valid();
        return exp_q.size() != 0;
    endfunction

    function automatic logic exp_full();
        return exp_q.size() == 4;
    endfunction

    // Drive one edge's inputs, advance the scoreboard, then wait until just
    // after the falling edge so outputs can be sampled.
    task automatic step(input logic [3:0] q_i, input logic en_i, input logic rdy_i);
        logic pop;
        logic push;
        logic wrap;
        int   n;
        Q         = q_i;
        en        = en_i;
        bus.ready = rdy_i;
        n    = exp_q.size();
        pop  = (n != 0) && rdy_i;
        push = en_i && (q_i != m_prev);
        wrap = (q_i < m_prev);
        m_epoch = m_epoch + {3'b000, wrap};
        m_prev  = q_i;
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (n == 4 && !pop) m_ovf = 1'b1;
            else exp_q.push_back({m_epoch, q_i});
        end
        @(negedge clock);
        #1;
    endtask

    // Pulse reset between edges and clear the scoreboard.
    task automatic apply_reset();
        reset_ = 1'b0;
        #2;
        exp_q.delete();
        m_prev  = 4'd0;
        m_epoch = 4'd0;
        m_ovf   = 1'b0;
        reset_  = 1'b1;
    endtask

    task automatic test_reset();
        reset_    = 1'b0;
        bus.ready = 1'b0;
        #1;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
        @(negedge clock);
        #1;
        apply_reset();
    endtask

    task automatic test_count();
        logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
        for (int i = 0; i < 6; i++) begin
            step(seq[i], 1'b1, 1'b1);
            checks++; if (bus.valid !== exp_valid()) begin errors++; $display("FAIL count_valid[%0d]: got %b expected %b", i, bus.valid, exp_valid()); end
            checks++; if (bus.dout !== exp_head()) begin errors++; $display("FAIL count_dout[%0d]: got %h expected %h", i, bus.dout, exp_head()); end
            checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL count_overflow[%0d]: got %b expected %b", i, bus.overflow, m_ovf); end
            if (i == 1) begin
                checks++; if (bus.dout !== 8'h01) begin errors++; $display("FAIL count_first_word: got %h expected 01", bus.dout); end
            end
        end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL count_idle_valid: got %b expected 0", bus.valid); end
    endtask

    task automatic test_wrap();
        logic [3:0] seq  [4] = '{4'hE, 4'hF, 4'h0, 4'h1};
        logic [7:0] want [4] = '{8'h0E, 8'h0F, 8'h10, 8'h11};
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 1'b1, 1'b1);
            checks++; if (bus.dout !== want[i]) begin errors++; $display("FAIL wrap_dout[%0d]: got %h expected %h", i, bus.dout, want[i]); end
            checks++; if (bus.valid !== exp_valid()) begin errors++; $display("FAIL wrap_valid[%0d]: got %b expected %b", i, bus.valid, exp_valid()); end
        end
        // Fifteen more full laps bring the epoch back to 0.
        for (int w = 0; w < 15; w++) begin
            for (int v = 2; v < 18; v++) begin
                step(4'(v), 1'b1, 1'b1);
                checks++; if (bus.dout !== exp_head()) begin errors++; $display("FAIL lap_dout[%0d.%0d]: got %h expected %h", w, v, bus.dout, exp_head()); end
                checks++; if (bus.valid !== exp_valid()) begin errors++; $display("FAIL lap_valid[%0d.%0d]: got %b expected %b", w, v, bus.valid, exp_valid()); end
                if (w == 14 && v == 15) begin
                    checks++; if (bus.dout !== 8'hFF) begin errors++; $display("FAIL lap_top_word: got %h expected ff", bus.dout); end
                end
                if (w == 14 && v == 16) begin
                    checks++; if (bus.dout !== 8'h00 || bus.valid !== 1'b1) begin errors++; $display("FAIL lap_epoch_wrap: got %h/%b expected 00/1", bus.dout, bus.valid); end
                end
            end
        end
        step(4'h1, 1'b1, 1'b1);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL wrap_drain_valid: got %b expected 0", bus.valid); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 6; i++) begin
            step(4'(i), 1'b1, 1'b0);
            checks++; if (bus.dout !== exp_head()) begin errors++; $display("FAIL ovf_dout[%0d]: got %h expected %h", i, bus.dout, exp_head()); end
            checks++; if (bus.full !== exp_full()) begin errors++; $display("FAIL ovf_full[%0d]: got %b expected %b", i, bus.full, exp_full()); end
            checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL ovf_flag[%0d]: got %b expected %b", i, bus.overflow, m_ovf); end
            if (i == 4) begin
                checks++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_four: got full=%b ovf=%b expected 1/0", bus.full, bus.overflow); end
            end
            if (i == 5) begin
                checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_at_five: got %b expected 1", bus.overflow); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.dout !== 8'(k + 1)) begin errors++; $display("FAIL drain_order[%0d]: got %h expected %h", k, bus.dout, 8'(k + 1)); end
            step(4'd6, 1'b1, 1'b1);
            checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL drain_sticky[%0d]: got %b expected 1", k, bus.overflow); end
        end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", bus.valid); end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            step(4'(i), 1'b1, 1'b0);
            checks++; if (bus.full !== exp_full()) begin errors++; $display("FAIL fpp_fill_full[%0d]: got %b expected %b", i, bus.full, exp_full()); end
        end
        step(4'd5, 1'b1, 1'b1);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b expected 1", bus.full); end
        checks++; if (bus.dout !== 8'h02) begin errors++; $display("FAIL fpp_head: got %h expected 02", bus.dout); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %b expected 0", bus.overflow); end
        for (int k = 0; k < 4; k++) begin
            step(4'd5, 1'b1, 1'b1);
            checks++; if (bus.dout !== exp_head()) begin errors++; $display("FAIL fpp_drain[%0d]: got %h expected %h", k, bus.dout, exp_head()); end
            checks++; if (bus.valid !== exp_valid()) begin errors++; $display("FAIL fpp_valid[%0d]: got %b expected %b", k, bus.valid, exp_valid()); end
        end
    endtask

    task automatic test_en_gate();
        logic [3:0] seq [3] = '{4'hF, 4'h0, 4'h1};
        for (int i = 0; i < 3; i++) begin
            step(seq[i], 1'b0, 1'b1);
            checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL gate_valid[%0d]: got %b expected 0", i, bus.valid); end
        end
        step(4'h2, 1'b1, 1'b1);
        checks++; if (bus.dout !== 8'h12) begin errors++; $display("FAIL gate_epoch_word: got %h expected 12", bus.dout); end
        checks++; if (bus.dout !== exp_head()) begin errors++; $display("FAIL gate_model: got %h expected %h", bus.dout, exp_head()); end
        step(4'h2, 1'b1, 1'b1);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL gate_drain: got %b expected 0", bus.valid); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 1; i <= 5; i++) step(4'(i), 1'b1, 1'b0);
        step(4'd5, 1'b1, 1'b1);
        bus.ready = 1'b0;
        checks++; if (bus.overflow !== 1'b1 || bus.valid !== 1'b1 || bus.dout !== 8'h02) begin
            errors++; $display("FAIL mid_setup: got ovf=%b valid=%b dout=%h expected 1/1/02", bus.overflow, bus.valid, bus.dout);
        end
        #2;
        reset_ = 1'b0;
        #1;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.valid); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL mid_dout: got %h expected 00", bus.dout); end
        exp_q.delete();
        m_prev  = 4'd0;
        m_epoch = 4'd0;
        m_ovf   = 1'b0;
        #1;
        reset_ = 1'b1;
        step(4'd5, 1'b1, 1'b0);
        checks++; if (bus.dout !== 8'h05) begin errors++; $display("FAIL mid_first_push: got %h expected 05", bus.dout); end
        checks++; if (bus.dout !== exp_head()) begin errors++; $display("FAIL mid_model: got %h expected %h", bus.dout, exp_head()); end
        step(4'd5, 1'b1, 1'b1);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL mid_drain: got %b expected 0", bus.valid); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_overflow();
        test_full_push_pop();
        test_en_gate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
